// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared state encoding, funct codes and widths for the HI/LO sequencer
package hilo_pkg;

    localparam int HILO_XLEN = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } hilo_state_e;

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;

    function automatic logic is_hilo_funct(input logic [5:0] f);
        logic r;
        case (f)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hilo_iter_unit.sv
// rtl/hilo_iter_unit.sv - one shift-add multiply or restoring divide step per enable
// Subtract path present only when HILO_DIV_EN is defined.
module hilo_iter_unit #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                step_i,
    input  logic                div_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN:0]     sum;

`ifdef HILO_DIV_EN
    logic [XLEN:0] add_a, add_b;
    logic          quo_bit;

    // Shared 33-bit adder: subtract via invert-plus-carry when dividing.
    // A set top bit means the shifted remainder already exceeds any divisor.
    always_comb begin
        add_a   = div_i ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
        add_b   = div_i ? ~{1'b0, b_q} : {1'b0, b_q};
        sum     = add_a + add_b + {{XLEN{1'b0}}, div_i};
        quo_bit = acc_q[2*XLEN-1] | ~sum[XLEN];
        b_d     = b_q;
        acc_d   = acc_q;
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, a_i};
            b_d   = b_i;
        end else if (step_i && div_i) begin
            acc_d = quo_bit ? {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                            : {acc_q[2*XLEN-2:0], 1'b0};
        end else if (step_i) begin
            acc_d = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        end
    end
`else
    always_comb begin
        sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        b_d   = b_q;
        acc_d = acc_q;
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, a_i};
            b_d   = b_i;
        end else if (step_i && !div_i) begin
            acc_d = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/hilo_sequencer.sv
// rtl/hilo_sequencer.sv - HI/LO multiply/divide sequencer with pipeline stall
// Divide support is built only when HILO_DIV_EN is defined.
module hilo_sequencer
    import hilo_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] mf_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            illegal
);

    hilo_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              illegal_q, illegal_d;
`ifdef HILO_DIV_EN
    logic              div_q, div_d;
    logic              negr_q, negr_d;
    logic              dz_q, dz_d;
`endif

    logic              dec_valid, signed_op, rs_neg, rt_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              load, step;
    logic [2*XLEN-1:0] acc, prod;

    assign dec_valid = issue_valid && (opcode == 6'd0);
    assign signed_op = (funct == F_MULT) || (funct == F_DIV);
    assign rs_neg    = signed_op & rs_data[XLEN-1];
    assign rt_neg    = signed_op & rt_data[XLEN-1];
    assign a_mag     = rs_neg ? -rs_data : rs_data;
    assign b_mag     = rt_neg ? -rt_data : rt_data;

    hilo_iter_unit #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .step_i (step),
        .div_i  (state_q == ST_DIV),
        .a_i    (a_mag),
        .b_i    (b_mag),
        .acc_o  (acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        illegal_d = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        prod      = neg_q ? -acc : acc;
`ifdef HILO_DIV_EN
        div_d     = div_q;
        negr_d    = negr_q;
        dz_d      = dz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dec_valid && !flush) begin
                    case (funct)
                        F_MTHI: hi_d = rs_data;
                        F_MTLO: lo_d = rs_data;
                        F_MULT, F_MULTU: begin
                            load    = 1'b1;
                            cnt_d   = '0;
                            neg_d   = rs_neg ^ rt_neg;
                            state_d = ST_MUL;
`ifdef HILO_DIV_EN
                            div_d   = 1'b0;
`endif
                        end
                        F_DIV, F_DIVU: begin
`ifdef HILO_DIV_EN
                            load    = 1'b1;
                            cnt_d   = '0;
                            neg_d   = rs_neg ^ rt_neg;
                            negr_d  = rs_neg;
                            dz_d    = (rt_data == '0);
                            div_d   = 1'b1;
                            state_d = ST_DIV;
`else
                            illegal_d = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
            end
`ifdef HILO_DIV_EN
            ST_DIV: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
            end
`endif
            ST_FIX: begin
                state_d = ST_IDLE;
`ifdef HILO_DIV_EN
                // Divide by zero leaves the remainder equal to |rs|, so the sign fix restores rs.
                if (div_q) begin
                    hi_d = negr_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
                    lo_d = dz_q ? '1 : (neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
                end else begin
                    {hi_d, lo_d} = prod;
                end
`else
                {hi_d, lo_d} = prod;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            step    = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            illegal_q <= 1'b0;
`ifdef HILO_DIV_EN
            div_q     <= 1'b0;
            negr_q    <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            illegal_q <= illegal_d;
`ifdef HILO_DIV_EN
            div_q     <= div_d;
            negr_q    <= negr_d;
            dz_q      <= dz_d;
`endif
        end
    end

    always_comb begin
        mf_data = '0;
        if (dec_valid && state_q == ST_IDLE) begin
            if (funct == F_MFHI)      mf_data = hi_q;
            else if (funct == F_MFLO) mf_data = lo_q;
        end
    end

    assign stall   = dec_valid && is_hilo_funct(funct) && (state_q != ST_IDLE);
    assign busy    = (state_q != ST_IDLE);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_hilo_sequencer.sv
// tb/tb_hilo_sequencer.sv - scoreboard bench for hilo_sequencer
module tb_hilo_sequencer;

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;

    logic        clk = 1'b0;
    logic        rst_n, issue_valid, flush;
    logic [5:0]  opcode, funct;
    logic [31:0] rs_data, rt_data;
    logic        stall, busy, illegal;
    logic [31:0] mf_data, hi, lo;

    always #5 clk = ~clk;

    hilo_sequencer #(.XLEN(32), .ITER(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .opcode      (opcode),
        .funct       (funct),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .mf_data     (mf_data),
        .hi          (hi),
        .lo          (lo),
        .illegal     (illegal)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t        exp_res[$];
    logic [31:0] exp_mf[$];
    int          checks = 0;
    int          failures = 0;
    logic        busy_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        issue_valid = 1'b1;
        opcode      = 6'd0;
        funct       = f;
        rs_data     = a;
        rt_data     = b;
    endtask

    task automatic idle_bus();
        issue_valid = 1'b0;
        funct       = 6'd0;
    endtask

    task automatic push_res(input logic [31:0] h, input logic [31:0] l);
        res_t r;
        r.hi = h;
        r.lo = l;
        exp_res.push_back(r);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            cycle();
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout actual=busy required=idle");
        end
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l);
        issue(f, a, b);
        push_res(h, l);
        cycle();
        idle_bus();
        wait_idle();
    endtask

    // Monitor: completions (busy falling) and unstalled MFHI/MFLO reads.
    always @(negedge clk) begin
        res_t r;
        if (busy_prev && !busy) begin
            if (exp_res.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_completion actual=hi %h lo %h required=none", hi, lo);
            end else begin
                r = exp_res.pop_front();
                chk("result_hi", hi, r.hi);
                chk("result_lo", lo, r.lo);
            end
        end
        if (rst_n && issue_valid && opcode == 6'd0 && (funct == F_MFHI || funct == F_MFLO)
            && !stall && !flush) begin
            if (exp_mf.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_mf actual=%h required=none", mf_data);
            end else begin
                chk("mf_data", mf_data, exp_mf.pop_front());
            end
        end
        busy_prev = busy;
    end

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0;
        opcode = 6'd0; funct = 6'd0; rs_data = '0; rt_data = '0;
        repeat (2) cycle();
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_stall", stall, 0);
        chk("reset_illegal", illegal, 0);
        chk("reset_mf_data", mf_data, 0);
        rst_n = 1'b1;
        cycle();

        // MULT -3 * 7, busy length, non-HI/LO instructions never stall
        issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
        #1 chk("start_no_stall", stall, 0);
        push_res(32'hFFFF_FFFF, 32'hFFFF_FFEB);
        cycle();
        issue_valid = 1'b1; opcode = 6'd0; funct = 6'd32;
        #1 chk("add_no_stall", stall, 0);
        opcode = 6'h23; funct = F_MFHI;
        #1 chk("nonzero_opcode_no_stall", stall, 0);
        opcode = 6'd0;
        idle_bus();
        n = 0;
        while (busy && n < 100) begin
            n++;
            cycle();
        end
        chk("mult_busy_cycles", n, 33);

        // MULTU all-ones squared followed by a stalled MFLO
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push_res(32'hFFFF_FFFE, 32'h0000_0001);
        cycle();
        issue(F_MFLO, 32'd0, 32'd0);
        exp_mf.push_back(32'h0000_0001);
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            cycle();
        end
        chk("mflo_stall_cycles", n, 33);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        cycle();
        idle_bus();

        // Back-to-back MULT accepted the cycle after completion
        issue(F_MULT, 32'd5, 32'd6);
        push_res(32'd0, 32'd30);
        cycle();
        issue(F_MULT, 32'd2, 32'hFFFF_FFFC);
        push_res(32'hFFFF_FFFF, 32'hFFFF_FFF8);
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            cycle();
        end
        chk("b2b_stall_cycles", n, 33);
        cycle();
        chk("b2b_no_bubble_busy", busy, 1);
        idle_bus();
        wait_idle();

        // MTHI/MTLO, flush in IDLE, flush mid-MULT
        issue(F_MTHI, 32'h0000_AAAA, 32'd0);
        cycle();
        chk("mthi_hi", hi, 32'h0000_AAAA);
        issue(F_MTLO, 32'h0000_5555, 32'd0);
        cycle();
        chk("mtlo_lo", lo, 32'h0000_5555);
        issue(F_MTLO, 32'h0000_0077, 32'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_idle_lo", lo, 32'h0000_5555);
        issue(F_MULT, 32'd3, 32'd3);
        push_res(32'h0000_AAAA, 32'h0000_5555);
        cycle();
        idle_bus();
        repeat (9) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_hi", hi, 32'h0000_AAAA);
        issue(F_MFHI, 32'd0, 32'd0);
        exp_mf.push_back(32'h0000_AAAA);
        #1 chk("mfhi_after_flush_stall", stall, 0);
        cycle();
        idle_bus();

        // Signed extreme and unsigned multiply
        run_op(F_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op(F_MULTU, 32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0000_0000);

`ifdef HILO_DIV_EN
        run_op(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op(F_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        run_op(F_DIV, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op(F_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001);
        issue(F_DIV, 32'd100, 32'd7);
`else
        issue(F_DIV, 32'd100, 32'd7);
        #1 chk("illegal_div_no_stall", stall, 0);
        cycle();
        idle_bus();
        chk("illegal_pulse", illegal, 1);
        chk("illegal_busy", busy, 0);
        cycle();
        chk("illegal_one_cycle", illegal, 0);
        chk("illegal_hi", hi, 32'h0000_0001);
        chk("illegal_lo", lo, 32'h0000_0000);
        issue(F_MULT, 32'd100, 32'd7);
`endif
        // Reset mid-operation
        push_res(32'd0, 32'd0);
        cycle();
        idle_bus();
        repeat (5) cycle();
        rst_n = 1'b0;
        cycle();
        chk("midop_reset_hi", hi, 0);
        chk("midop_reset_lo", lo, 0);
        chk("midop_reset_busy", busy, 0);
        rst_n = 1'b1;
        repeat (3) cycle();

        chk("res_queue_empty", exp_res.size(), 0);
        chk("mf_queue_empty", exp_mf.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
